saanvi_multimode_counter: RTL and testbench

//   Parametrised successor to the tile's fixed 8-bit counter.

---
 rtl/saanvi_multimode_counter.sv | 179 +++++++++++++++++
 tb/tb_saanvi_multimode_counter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/saanvi_multimode_counter.sv
// Multimode prescaled counter: free-run, modulo, one-shot and ping-pong
// counting with up/down control, parallel load, terminal-count pulse and a
// sticky one-shot done flag. All state is updated on the rising clock edge
// with a synchronous active-high reset.
module saanvi_multimode_counter #(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  dir,
   input  logic [1:0]            mode,
   input  logic                  load,
   input  logic [WIDTH-1:0]      load_val,
   input  logic [WIDTH-1:0]      mod_val,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic [WIDTH-1:0]      count,
   output logic                  tc,
   output logic                  done,
   output logic                  dir_q
);

   typedef enum logic [1:0] {
      MODE_FREE     = 2'b00,
      MODE_MODULO   = 2'b01,
      MODE_ONESHOT  = 2'b10,
      MODE_PINGPONG = 2'b11
   } mode_e;

   localparam logic [WIDTH-1:0]      CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [PRESCALE_W-1:0] PRE_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

   mode_e                 mode_sel;
   mode_e                 mode_q,  mode_d;
   logic [WIDTH-1:0]      count_q, count_d;
   logic [PRESCALE_W-1:0] pre_q,   pre_d;
   logic                  tc_q,    tc_d;
   logic                  done_q,  done_d;
   logic                  dir_state_q, dir_d;

   logic                  tick;
   logic                  pp_dir;
   logic [WIDTH-1:0]      count_inc;
   logic [WIDTH-1:0]      count_dec;

   assign mode_sel  = mode_e'(mode);
   assign tick      = en && (pre_q == prescale);
   assign count_inc = count_q + CNT_ONE;
   assign count_dec = count_q - CNT_ONE;
   // Ping-pong always starts upward on the first cycle spent in mode 11.
   assign pp_dir    = (mode_q == MODE_PINGPONG) ? dir_state_q : 1'b0;

   // Next-state: priority load > tick; prescaler, mode-dependent stepping, flags.
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path
      // leaves one unassigned and no latch is inferred.
      count_d = count_q;
      pre_d   = pre_q;
      tc_d    = 1'b0;
      done_d  = done_q;
      mode_d  = mode_sel;
      dir_d   = (mode_sel == MODE_PINGPONG) ? pp_dir : dir;

      if (mode_sel != MODE_ONESHOT) begin
         done_d = 1'b0;
      end

      if (load) begin
         count_d = load_val;
         pre_d   = '0;
         done_d  = 1'b0;
         if (mode_sel == MODE_PINGPONG) begin
            dir_d = 1'b0;
         end
      end else begin
         if (tick) begin
            pre_d = '0;
         end else if (en) begin
            pre_d = pre_q + PRE_ONE;
         end

         if (tick) begin
            unique case (mode_sel)
               MODE_FREE: begin
                  count_d = dir ? count_dec : count_inc;
                  tc_d    = dir ? (count_q == '0) : (count_q == '1);
               end
               MODE_MODULO: begin
                  if (!dir) begin
                     if (count_q >= mod_val) begin
                        count_d = '0;
                        tc_d    = 1'b1;
                     end else begin
                        count_d = count_inc;
                     end
                  end else if ((count_q == '0) || (count_q > mod_val)) begin
                     count_d = mod_val;
                     tc_d    = 1'b1;
                  end else begin
                     count_d = count_dec;
                  end
               end
               MODE_ONESHOT: begin
                  if (!done_q) begin
                     if (!dir) begin
                        if (count_q >= mod_val) begin
                           done_d = 1'b1;
                           tc_d   = 1'b1;
                        end else begin
                           count_d = count_inc;
                           done_d  = (count_inc == mod_val);
                           tc_d    = (count_inc == mod_val);
                        end
                     end else if (count_q == '0) begin
                        done_d = 1'b1;
                        tc_d   = 1'b1;
                     end else begin
                        count_d = count_dec;
                        done_d  = (count_q == CNT_ONE);
                        tc_d    = (count_q == CNT_ONE);
                     end
                  end
               end
               MODE_PINGPONG: begin
                  if (mod_val == '0) begin
                     count_d = '0;
                     tc_d    = 1'b1;
                  end else if (!pp_dir) begin
                     if (count_q >= mod_val) begin
                        dir_d   = 1'b1;
                        count_d = count_dec;
                        tc_d    = (count_q == CNT_ONE);
                     end else begin
                        count_d = count_inc;
                        tc_d    = (count_inc == mod_val);
                     end
                  end else if (count_q == '0) begin
                     dir_d   = 1'b0;
                     count_d = CNT_ONE;
                     tc_d    = (mod_val == CNT_ONE);
                  end else begin
                     count_d = count_dec;
                     tc_d    = (count_q == CNT_ONE);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers
      // update together from values sampled before the edge.
      if (rst) begin
         count_q     <= '0;
         pre_q       <= '0;
         tc_q        <= 1'b0;
         done_q      <= 1'b0;
         dir_state_q <= 1'b0;
         mode_q      <= MODE_FREE;
      end else begin
         count_q     <= count_d;
         pre_q       <= pre_d;
         tc_q        <= tc_d;
         done_q      <= done_d;
         dir_state_q <= dir_d;
         mode_q      <= mode_d;
      end
   end

   assign count = count_q;
   assign tc    = tc_q;
   assign done  = done_q;
   assign dir_q = dir_state_q;

endmodule

// File: tb/tb_saanvi_multimode_counter.sv
// Scoreboard bench for saanvi_multimode_counter: directed sequences followed
// by randomized stimulus, all checked against an arithmetic reference model.
module tb_saanvi_multimode_counter;

   typedef struct packed {
      logic [7:0] count;
      logic       tc;
      logic       done;
      logic       dir;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst, en, dir, load;
   logic [1:0] mode;
   logic [7:0] load_val, mod_val;
   logic [3:0] prescale;
   logic [7:0] count;
   logic       tc, done, dir_q;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state (plain integers).
   int m_cnt  = 0;
   int m_pre  = 0;
   int m_prev = 0;
   bit m_done = 1'b0;
   bit m_dir  = 1'b0;

   always #5 clk = ~clk;

   saanvi_multimode_counter #(.WIDTH(8), .PRESCALE_W(4)) dut (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
      .load_val(load_val), .mod_val(mod_val), .prescale(prescale),
      .count(count), .tc(tc), .done(done), .dir_q(dir_q)
   );

   // Advance the model by one clock edge using the current inputs.
   task automatic model_step(output exp_t x);
      bit tick;
      bit tcv;
      bit newdir;
      int m;
      int mv;
      tcv = 1'b0;
      m   = int'(mode);
      mv  = int'(mod_val);
      if (rst) begin
         m_cnt = 0; m_pre = 0; m_done = 0; m_prev = 0; newdir = 0;
      end else begin
         tick   = en && (m_pre == int'(prescale));
         newdir = (m == 3) ? ((m_prev == 3) ? m_dir : 1'b0) : dir;
         if (m != 2) m_done = 0;
         if (load) begin
            m_cnt = int'(load_val); m_pre = 0; m_done = 0;
            if (m == 3) newdir = 0;
         end else begin
            if (tick) m_pre = 0;
            else if (en) m_pre = (m_pre + 1) % 16;
            if (tick) begin
               case (m)
                  0: begin
                     m_cnt = dir ? (m_cnt + 255) % 256 : (m_cnt + 1) % 256;
                     tcv   = dir ? (m_cnt == 255) : (m_cnt == 0);
                  end
                  1: begin
                     if (!dir) begin
                        if (m_cnt >= mv) begin m_cnt = 0; tcv = 1; end
                        else m_cnt++;
                     end else begin
                        if (m_cnt == 0 || m_cnt > mv) begin m_cnt = mv; tcv = 1; end
                        else m_cnt--;
                     end
                  end
                  2: begin
                     if (!m_done) begin
                        if (!dir) begin
                           if (m_cnt < mv) m_cnt++;
                           if (m_cnt >= mv) begin m_done = 1; tcv = 1; end
                        end else begin
                           if (m_cnt > 0) m_cnt--;
                           if (m_cnt == 0) begin m_done = 1; tcv = 1; end
                        end
                     end
                  end
                  default: begin
                     if (mv == 0) begin
                        m_cnt = 0; tcv = 1;
                     end else begin
                        if (!newdir && m_cnt >= mv) newdir = 1;
                        else if (newdir && m_cnt == 0) newdir = 0;
                        m_cnt = newdir ? m_cnt - 1 : m_cnt + 1;
                        tcv   = newdir ? (m_cnt == 0) : (m_cnt == mv);
                     end
                  end
               endcase
            end
         end
         m_prev = m;
      end
      m_dir   = newdir;
      x.count = 8'(m_cnt);
      x.tc    = tcv;
      x.done  = m_done;
      x.dir   = m_dir;
   endtask

   // Drive one cycle of stimulus, push the expected post-edge outputs.
   task automatic step(input bit r, input bit e, input bit d, input bit [1:0] m,
                       input bit l, input bit [7:0] lv, input bit [7:0] mv,
                       input bit [3:0] ps);
      exp_t x;
      rst = r; en = e; dir = d; mode = m; load = l;
      load_val = lv; mod_val = mv; prescale = ps;
      model_step(x);
      sb_q.push_back(x);
      @(posedge clk);
      #2;
   endtask

   task automatic run(input int n, input bit d, input bit [1:0] m,
                      input bit [7:0] mv, input bit [3:0] ps);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, d, m, 1'b0, 8'h00, mv, ps);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 8'h00, 4'h0);
   endtask

   // Monitor: every edge produces an output word; compare against the queue.
   initial begin
      exp_t e;
      exp_t got;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            got = '{count, tc, done, dir_q};
            checks++;
            if (got !== e) begin
               errors++;
               $display("FAIL outputs t=%0t got count=%0d tc=%b done=%b dir_q=%b want count=%0d tc=%b done=%b dir_q=%b",
                        $time, got.count, got.tc, got.done, got.dir, e.count, e.tc, e.done, e.dir);
            end
         end
      end
   end

   initial begin
      bit       r_d, r_en, r_l;
      bit [1:0] r_m;
      bit [7:0] r_mv;
      bit [3:0] r_ps;
      int       wait_cycles;

      // 1. free-run up through a full wrap
      do_reset(3);
      run(260, 1'b0, 2'b00, 8'd0, 4'd0);
      run(6, 1'b1, 2'b00, 8'd0, 4'd0);

      // 2. modulo 9 with prescale 2, then down from 0
      do_reset(1);
      run(40, 1'b0, 2'b01, 8'd9, 4'd2);
      step(1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 8'd0, 8'd9, 4'd2);
      run(12, 1'b1, 2'b01, 8'd9, 4'd2);

      // 3. one-shot up to 5, hold, reload and resume
      do_reset(1);
      run(16, 1'b0, 2'b10, 8'd5, 4'd0);
      step(1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 8'd0, 8'd5, 4'd0);
      run(8, 1'b0, 2'b10, 8'd5, 4'd0);
      run(4, 1'b1, 2'b10, 8'd5, 4'd0);

      // 4. ping-pong between 0 and 3
      do_reset(1);
      run(20, 1'b0, 2'b11, 8'd3, 4'd0);

      // 5. load colliding with a tick, then reset mid-count
      run(3, 1'b0, 2'b00, 8'd0, 4'd0);
      step(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 8'hA5, 8'd0, 4'd0);
      run(3, 1'b0, 2'b00, 8'd0, 4'd1);
      step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 8'd0, 4'd1);
      run(2, 1'b0, 2'b00, 8'd0, 4'd1);

      // 6. modulo with count above mod_val; en low freezes everything
      step(1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 8'd20, 8'd9, 4'd0);
      run(4, 1'b0, 2'b01, 8'd9, 4'd3);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 8'd0, 8'd9, 4'd3);
      run(8, 1'b0, 2'b01, 8'd9, 4'd3);

      // Random phase: sticky settings with occasional changes.
      r_d = 0; r_m = 2'b00; r_mv = 8'd7; r_ps = 4'd0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(63) == 0) r_m = 2'($urandom_range(3));
         if ($urandom_range(49) == 0) r_d = ~r_d;
         if ($urandom_range(99) == 0)
            r_mv = ($urandom_range(3) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(12));
         if ($urandom_range(99) == 0) r_ps = ($urandom_range(7) == 0) ? 4'd15 : 4'($urandom_range(3));
         r_en = ($urandom_range(9) != 0);
         r_l  = ($urandom_range(39) == 0);
         step(($urandom_range(299) == 0), r_en, r_d, r_m, r_l,
              8'($urandom_range(255)), r_mv, r_ps);
      end

      wait_cycles = 0;
      while (sb_q.size() > 0 && wait_cycles < 10) begin
         @(posedge clk);
         wait_cycles++;
      end
      #3;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
